// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave for a 1-cycle synchronous SRAM: zero-wait reads, writes parked in a one-entry buffer.
// Never stalls legal transfers; illegal size/alignment gets a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [3:0]            HMASTER,
    input  logic [31:0]           HWDATA,
    input  logic                  HMASTLOCK,
    input  logic                  HREADYMUX,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic                  SRAM_CS,
    output logic [3:0]            SRAM_WE,
    output logic [ADDR_WIDTH-3:0] SRAM_ADDR,
    output logic [31:0]           SRAM_WDATA,
    input  logic [31:0]           SRAM_RDATA
);

    localparam int WA = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_wr_pend;
    logic [WA-1:0]   r_wr_addr;
    logic [3:0]      r_wr_be;
    logic            r_rd_pend;
    logic [WA-1:0]   r_rd_addr;
    logic            r_buf_vld;
    logic [WA-1:0]   r_buf_addr;
    logic [3:0]      r_buf_be;
    logic [31:0]     r_buf_data;

    logic            w_valid;
    logic            w_illegal;
    logic            w_bad;
    logic            w_rd;
    logic            w_wr;
    logic [3:0]      w_be;
    logic            w_load;
    logic            w_drain;
    logic            w_hit;
    logic [WA-1:0]   w_haddr_word;

    wire w_unused = ^{HBURST, HPROT, HMASTER, HMASTLOCK, HADDR[31:ADDR_WIDTH]};

    assign w_haddr_word = HADDR[ADDR_WIDTH-1:2];

    // Reset gates acceptance so nothing reaches the SRAM while HRESET is held.
    assign w_valid   = HSEL & HREADYMUX & HTRANS[1] & ~HRESET;
    assign w_illegal = (HSIZE > 3'd2)
                     | ((HSIZE == 3'd1) & HADDR[0])
                     | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign w_bad     = w_valid & w_illegal;
    assign w_rd      = w_valid & ~w_illegal & ~HWRITE;
    assign w_wr      = w_valid & ~w_illegal & HWRITE;

    always_comb begin
        w_be = 4'b1111;
        case (HSIZE[1:0])
            2'd0:    w_be = 4'b0001 << HADDR[1:0];
            2'd1:    w_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_load  = r_wr_pend & HREADYMUX & ~HRESET;
    assign w_drain = r_buf_vld & ~w_rd & ~HRESET;
    assign w_hit   = r_buf_vld & (r_buf_addr == r_rd_addr);

    always_comb begin
        w_state_nxt = r_state;
        HREADYOUT   = 1'b1;
        HRESP       = 2'b00;
        case (r_state)
            ST_OK: begin
                if (w_bad) w_state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 2'b01;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP       = 2'b01;
                w_state_nxt = w_bad ? ST_ERR1 : ST_OK;
            end
            default: w_state_nxt = ST_OK;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= ST_OK;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_buf_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (HREADYMUX) begin
                r_wr_pend <= w_wr;
                r_rd_pend <= w_rd;
            end
            // A load in the same cycle as a drain wins: the drain already used the old contents.
            if (w_load)
                r_buf_vld <= 1'b1;
            else if (w_drain)
                r_buf_vld <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_wr) begin
            r_wr_addr <= w_haddr_word;
            r_wr_be   <= w_be;
        end
        if (w_rd)
            r_rd_addr <= w_haddr_word;
        if (w_load) begin
            r_buf_addr <= r_wr_addr;
            r_buf_be   <= r_wr_be;
            r_buf_data <= HWDATA;
        end
    end

    always_comb begin
        SRAM_CS    = 1'b0;
        SRAM_WE    = 4'b0000;
        SRAM_ADDR  = r_buf_addr;
        SRAM_WDATA = r_buf_data;
        if (w_rd) begin
            SRAM_CS   = 1'b1;
            SRAM_ADDR = w_haddr_word;
        end else if (w_drain) begin
            SRAM_CS = 1'b1;
            SRAM_WE = r_buf_be;
        end
    end

    // Bytes still sitting in the write buffer are newer than the SRAM copy.
    always_comb begin
        HRDATA = 32'h0;
        if (r_rd_pend) begin
            for (int i = 0; i < 4; i++)
                HRDATA[8*i +: 8] = (w_hit & r_buf_be[i]) ? r_buf_data[8*i +: 8]
                                                         : SRAM_RDATA[8*i +: 8];
        end
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave that terminates bus output port 2 (System SRAM) and drives a single-port synchronous SRAM macro with 1-cycle read latency.
- Runs at zero wait states for all legal transfers.
- Write data arrives in the AHB data phase, so each write is parked in a one-entry write buffer. The buffer is drained to SRAM in the next cycle that carries no read.
- Read-after-write hazards are resolved by byte-merging buffer contents into read data.

Parameters:
ADDR_WIDTH, 16, byte-address bits decoded (memory = 2^ADDR_WIDTH bytes; HADDR upper bits ignored)

Ports:
HCLK  in  1  system clock, all logic on rising edge
HRESET  in  1  synchronous reset, active-high
HSEL  in  1  slave select from bus
HADDR  in  32  address
HTRANS  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HBURST  in  3  burst type (ignored)
HPROT  in  4  protection (ignored)
HMASTER  in  4  master id (ignored)
HWDATA  in  32  write data, valid in data phase
HMASTLOCK  in  1  locked (ignored)
HREADYMUX  in  1  bus-level HREADY
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  2  00 OKAY, 01 ERROR
SRAM_CS  out  1  SRAM chip select
SRAM_WE  out  4  byte write enables (0 = read when CS)
SRAM_ADDR  out  ADDR_WIDTH-2  word address
SRAM_WDATA  out  32  SRAM write data
SRAM_RDATA  in  32  SRAM read data, valid cycle after CS with WE=0

Behaviour:
- Reset (HRESET high at edge) has these effects:
  - HREADYOUT=1, HRESP=00, HRDATA=0.
  - SRAM_CS=0, SRAM_WE=0.
  - Write buffer invalid; error FSM goes to OK.
  - Any pending buffered write is discarded (never reaches SRAM).
- Valid transfer: HSEL & HREADYMUX & HTRANS[1]. IDLE/BUSY and unselected cycles get an OKAY zero-wait response and have no side effects.
- Illegal transfers are HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]≠0. A valid transfer that is illegal enters the ERROR response, with no SRAM access and no buffer capture.
- Byte enables (little-endian):
  - byte: 1<<HADDR[1:0]
  - halfword: 4'b0011<<(2*HADDR[1])
  - word: 4'b1111
- Response FSM states OK, ERR1, ERR2:
  - OK→ERR1 on an illegal valid transfer.
  - ERR1: HREADYOUT=0, HRESP=01, then →ERR2.
  - ERR2: HREADYOUT=1, HRESP=01, then →ERR1 if a new illegal valid transfer is present, else →OK.
  - OK: HREADYOUT=1, HRESP=00.
- SRAM port priority each cycle:
  1. Legal valid read address phase: CS=1, WE=0, SRAM_ADDR=HADDR[ADDR_WIDTH-1:2].
  2. Else, buffer valid: CS=1, WE=buf_be, ADDR=buf_addr, WDATA=buf_data; buffer invalidated at edge.
  3. Else: CS=0.
- Write path:
  - At the address phase, the word address and byte enables are registered.
  - At the end of the data phase (HREADYMUX=1), HWDATA, the address and the enables load the buffer (buf_valid=1).
  - The buffer is guaranteed empty at load: the write's address phase had no read, so it drained the buffer.
  - If a drain and a load occur in the same cycle, the drain uses the old contents and the load wins the register.
- Read path:
  - Data phase follows one cycle after the address phase.
  - HRDATA = SRAM_RDATA with each byte i replaced by buf_data[i] when buf_valid & buf_addr==read word addr & buf_be[i].
  - HRDATA=0 outside read data phases.
- Total read latency is 1 cycle (pure AHB data phase), with no wait states.
- Back-to-back W→R to the same address returns the new data via merge.
- HBURST is ignored: each beat is decoded independently.

Test Plan:
- Reset: hold HRESET 2 cycles with random bus inputs -> HREADYOUT=1, HRESP=00, HRDATA=0, SRAM_CS=0 throughout, and on the first cycle after release.
- Word write 0xDEADBEEF @0x10, then NONSEQ word read @0x10 in the immediately following cycle -> read data phase HRDATA=0xDEADBEEF with HREADYOUT=1; the SRAM write occurs on the next non-read cycle.
- Preload word 0x11223344 @0x20, byte write 0xAA @0x21, then word read @0x20 -> HRDATA=0x1122AA44; the drain later has SRAM_WE=4'b0010.
- Halfword write @0x03 -> cycle 1 HREADYOUT=0/HRESP=01, cycle 2 HREADYOUT=1/HRESP=01, SRAM_WE never nonzero, buffer stays invalid.
- Word read with HSIZE=3'b011 @0x40 followed by a legal read @0x44 -> ERR1/ERR2 sequence, then the @0x44 read returns correct data with OKAY.
- Word write 0x55AA55AA @0x80 (old 0x0), then HRESET asserted in the data-phase+1 cycle before any drain, then read @0x80 -> HRDATA=0x00000000, and SRAM_WE stays 0 for that write.
